// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: word RAM plus MMIO cycle counter and byte TX FIFO (optional DMEM_ALIGN_CHECK_EN)
module dmem_responder #(
  parameter int n           = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         memwrite,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] writedata,
  output logic [n-1:0] readdata,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         fault
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] SEL_CYCLE  = 2'd0;
  localparam logic [1:0] SEL_TXDATA = 2'd1;
  localparam logic [1:0] SEL_STATUS = 2'd2;

  logic [n-1:0]  mem [DEPTH_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [n-1:0]  cycle;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [15:0]   drop;

  logic [AW-1:0] word_idx;
  logic [1:0]    sel;
  logic          is_mmio;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          accept;
  logic          drop_ev;
  logic          unused_addr_bits;

  assign word_idx = addr[AW+1:2];
  assign sel      = addr[3:2];
  assign is_mmio  = addr[n-1];

  // Upper RAM-index bits alias by design and the byte offset only matters with the alignment check.
  assign unused_addr_bits = ^{addr[n-2:AW+2], addr[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  logic fault_q;

  // A misaligned store has no side effect anywhere; a write while reset is held is dropped.
  assign wr_en = memwrite && reset && (addr[1:0] == 2'b00);
  assign fault = fault_q;

  // Sticky misaligned-store flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fault_q <= 1'b0;
    end else if (memwrite && (addr[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end
`else
  // Byte offset ignored; a write while reset is held is dropped.
  assign wr_en = memwrite && reset;
  assign fault = 1'b0;
`endif

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push    = wr_en && is_mmio && (sel == SEL_TXDATA);
  assign pop     = !empty && out_ready;
  assign accept  = push && (!full || pop);
  assign drop_ev = push && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  // Word RAM store; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en && !is_mmio) begin
      mem[word_idx] <= writedata;
    end
  end

  // FIFO byte storage; stale entries are never visible because out_data is masked when empty.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_mem[wr_ptr] <= writedata[7:0];
    end
  end

  // Free-running cycle counter; a store to CYCLE takes precedence over the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle <= '0;
    end else if (wr_en && is_mmio && (sel == SEL_CYCLE)) begin
      cycle <= writedata;
    end else begin
      cycle <= cycle + 1'b1;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      drop   <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (accept && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !accept) begin
        count <= count - 1'b1;
      end
      if (drop_ev && (drop != 16'hFFFF)) begin
        drop <= drop + 1'b1;
      end
    end
  end

  // Combinational read mux so the cpu sees data in the same cycle.
  always_comb begin
    readdata = '0;
    if (!is_mmio) begin
      readdata = mem[word_idx];
    end else begin
      case (sel)
        SEL_CYCLE:  readdata = cycle;
        SEL_STATUS: readdata = n'({drop, {(8-CW){1'b0}}, count, 6'b000000, full, empty});
        default:    readdata = '0;
      endcase
    end
  end

endmodule
